// File: rtl/frame_streamer_pkg.sv
// Shared types, defaults and helpers for the frame streamer.
package frame_streamer_pkg;

  localparam int WIDTH_DEF   = 256;
  localparam int HEIGHT_DEF  = 256;
  localparam int MIN_GAP_DEF = 8;
  localparam int AW_DEF      = 16;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EMIT,
    WAIT
  } state_t;

  // The filter pipeline needs at least min_gap cycles between strobes, so
  // shorter requested periods are stretched to that floor.
  function automatic logic [3:0] clamp_gap(input logic [3:0] gap, input int min_gap);
    if (int'(gap) < min_gap) begin
      return 4'(min_gap);
    end
    return gap;
  endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Host write bus plus the strobed pixel stream that feeds the 2D filter.
interface frame_streamer_if #(
  parameter int AW = 16
) ();

  logic          h_write;
  logic [AW-1:0] h_addr;
  logic [7:0]    h_data;
  logic          o_strb;
  logic [7:0]    o_data;
  logic          o_sof;

  // Streamer side: consumes host writes, produces the pixel stream.
  modport master (
    input  h_write,
    input  h_addr,
    input  h_data,
    output o_strb,
    output o_data,
    output o_sof
  );

  // Host / filter side: issues writes, observes the pixel stream.
  modport slave (
    output h_write,
    output h_addr,
    output h_data,
    input  o_strb,
    input  o_data,
    input  o_sof
  );

endinterface

// File: rtl/mem_single.sv
// Single-port synchronous RAM with one-cycle read latency; contents are not reset.
module mem_single #(
  parameter int WD    = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] dout
);

  logic [WD-1:0] mem [DEPTH];

  // Write when selected with we, otherwise register the addressed word.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// Replays a host-preloaded frame raster-order to the 2D filter, one pixel
// every gap_r cycles, for a programmable number of frames.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int HEIGHT  = HEIGHT_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       cfg_gap,
  input  logic [7:0]       cfg_nframes,
  frame_streamer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             wr_err
);

  localparam int            PIXELS    = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

  state_t        state;
  state_t        next_state;

  logic [3:0]    gap_r;
  logic [7:0]    nfr_r;
  logic [AW-1:0] pix_addr;
  logic [7:0]    frame_cnt;
  logic [3:0]    gap_cnt;
  logic          stop_pend;

  logic          pix_strb;
  pixel_t        pix_data;
  logic          pix_sof;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  pixel_t        mem_dout;

  logic          start_ok;
  logic          wait_done;
  logic          last_done;
  logic          stop_now;
  logic          leaving;

  assign bus.o_strb = pix_strb;
  assign bus.o_data = pix_data;
  assign bus.o_sof  = pix_sof;

  // The host owns the memory port in IDLE; the streamer owns it otherwise.
  mem_single #(
    .WD   (8),
    .DEPTH(PIXELS),
    .AW   (AW)
  ) u_mem (
    .clk (clk),
    .cs  (mem_cs),
    .we  (mem_we),
    .addr(mem_addr),
    .din (bus.h_data),
    .dout(mem_dout)
  );

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and memory port steering.
  always_comb begin
    next_state = state;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pix_addr;
    start_ok   = 1'b0;
    leaving    = 1'b0;
    // WAIT lasts gap_r-2 cycles so READ+EMIT complete the period exactly.
    wait_done  = (gap_cnt == (gap_r - 4'd3));
    last_done  = (nfr_r != 8'd0) && (frame_cnt == nfr_r);
    // A stop landing on WAIT's final cycle must still prevent the next read.
    stop_now   = stop_pend | stop;
    case (state)
      IDLE: begin
        mem_cs   = bus.h_write;
        mem_we   = 1'b1;
        mem_addr = bus.h_addr;
        if (start && !stop) begin
          start_ok   = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        mem_cs     = 1'b1;
        next_state = EMIT;
      end
      EMIT: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_done) begin
          if (stop_now || last_done) begin
            leaving    = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = READ;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Run configuration, pixel/frame counters, outputs and status flags.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      gap_r     <= 4'd0;
      nfr_r     <= 8'd0;
      pix_addr  <= '0;
      frame_cnt <= 8'd0;
      gap_cnt   <= 4'd0;
      stop_pend <= 1'b0;
      pix_strb  <= 1'b0;
      pix_data  <= 8'd0;
      pix_sof   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      pix_strb <= 1'b0;
      pix_sof  <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            gap_r     <= clamp_gap(cfg_gap, MIN_GAP);
            nfr_r     <= cfg_nframes;
            pix_addr  <= '0;
            frame_cnt <= 8'd0;
            gap_cnt   <= 4'd0;
            stop_pend <= 1'b0;
            wr_err    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        EMIT: begin
          pix_strb <= 1'b1;
          pix_data <= mem_dout;
          pix_sof  <= (pix_addr == '0);
          gap_cnt  <= 4'd0;
          if (pix_addr == LAST_ADDR) begin
            pix_addr  <= '0;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            pix_addr <= pix_addr + AW'(1);
          end
        end
        WAIT: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (leaving) begin
            busy <= 1'b0;
            done <= !stop_now;
          end
        end
        default: begin
        end
      endcase
      if (state != IDLE) begin
        if (stop) begin
          stop_pend <= 1'b1;
        end
        if (bus.h_write) begin
          wr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Directed, table-driven bench for frame_streamer on a 4x4 frame.
module tb_frame_streamer;
  import frame_streamer_pkg::*;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int PIX    = W * H;
  localparam int BUDGET = 800;

  typedef struct {
    logic [3:0] gap;
    logic [7:0] nfr;
    int         stop_after;
    int         wr_cycle;
    int         exp_strobes;
    int         exp_period;
    int         exp_done;
    int         exp_sofs;
    int         exp_wr_err;
  } vec_t;

  logic       clk;
  logic       n_reset;
  logic       start;
  logic       stop;
  logic [3:0] cfg_gap;
  logic [7:0] cfg_nframes;
  logic       busy;
  logic       done;
  logic       wr_err;

  int         checks;
  int         errors;
  logic [7:0] model_mem [PIX];
  vec_t       vecs [7];
  vec_t       one_frame;

  frame_streamer_if #(.AW(4)) bus ();

  frame_streamer #(
    .WIDTH  (W),
    .HEIGHT (H),
    .MIN_GAP(8),
    .AW     (4)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .stop       (stop),
    .cfg_gap    (cfg_gap),
    .cfg_nframes(cfg_nframes),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic hostWrite(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.h_write = 1'b1;
    bus.h_addr  = addr;
    bus.h_data  = data;
    model_mem[addr] = data;
    @(negedge clk);
    bus.h_write = 1'b0;
  endtask

  // Start one run and follow it at every falling edge until busy has been low
  // for a little over a period, checking every strobe as it appears.
  task automatic applyStimulus(input vec_t v);
    int c;
    int n_strb;
    int n_done;
    int n_sof;
    int last_c;
    int done_c;
    int busy_fall_c;
    int stop_at;
    int finished;
    @(negedge clk);
    cfg_gap     = v.gap;
    cfg_nframes = v.nfr;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    c = 1; n_strb = 0; n_done = 0; n_sof = 0; last_c = 0;
    done_c = -1; busy_fall_c = -1; stop_at = -1; finished = 0;
    while (finished == 0 && c < BUDGET) begin
      if (bus.o_strb) begin
        checkOutput("strobe_time", c, 3 + n_strb * v.exp_period);
        checkOutput("pixel_data", int'(bus.o_data), int'(model_mem[n_strb % PIX]));
        checkOutput("sof_flag", int'(bus.o_sof), int'((n_strb % PIX) == 0));
        n_sof  += int'(bus.o_sof);
        n_strb++;
        last_c = c;
        if (v.stop_after != 0 && n_strb == v.stop_after) stop_at = c + 2;
      end
      if (done) begin
        n_done++;
        done_c = c;
      end
      if (!busy && busy_fall_c < 0) busy_fall_c = c;
      if (busy_fall_c >= 0 && c >= busy_fall_c + v.exp_period + 4) finished = 1;
      stop        = (c == stop_at);
      bus.h_write = (c == v.wr_cycle);
      bus.h_addr  = 4'd3;
      bus.h_data  = 8'hAA;
      @(negedge clk);
      c++;
    end
    stop        = 1'b0;
    bus.h_write = 1'b0;
    checkOutput("run_completed", finished, 1);
    checkOutput("strobe_count", n_strb, v.exp_strobes);
    checkOutput("sof_count", n_sof, v.exp_sofs);
    checkOutput("done_pulses", n_done, v.exp_done);
    if (v.exp_done != 0) checkOutput("done_cycle", done_c, last_c + v.exp_period - 2);
    checkOutput("busy_fall_cycle", busy_fall_c, last_c + v.exp_period - 2);
    checkOutput("wr_err", int'(wr_err), v.exp_wr_err);
  endtask

  initial begin
    int seen;
    int busy_seen;
    int strb_seen;
    checks = 0;
    errors = 0;

    //          gap    nfr    stop wr  strb per done sof err
    vecs[0] = '{4'd8,  8'd1,  0,   0,  16,  8,  1,   1,  0};
    vecs[1] = '{4'd3,  8'd1,  0,   0,  16,  8,  1,   1,  0};
    vecs[2] = '{4'd12, 8'd1,  0,   0,  16,  12, 1,   1,  0};
    vecs[3] = '{4'd0,  8'd1,  0,   0,  16,  8,  1,   1,  0};
    vecs[4] = '{4'd15, 8'd1,  0,   0,  16,  15, 1,   1,  0};
    vecs[5] = '{4'd8,  8'd2,  0,   10, 32,  8,  1,   2,  1};
    vecs[6] = '{4'd8,  8'd0,  5,   0,  5,   8,  0,   1,  0};
    one_frame = vecs[0];

    n_reset     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    cfg_gap     = 4'd0;
    cfg_nframes = 8'd0;
    bus.h_write = 1'b0;
    bus.h_addr  = 4'd0;
    bus.h_data  = 8'd0;

    @(negedge clk);
    checkOutput("reset_o_strb", int'(bus.o_strb), 0);
    checkOutput("reset_o_data", int'(bus.o_data), 0);
    checkOutput("reset_o_sof", int'(bus.o_sof), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_wr_err", int'(wr_err), 0);
    n_reset = 1'b1;

    for (int a = 0; a < PIX; a++) hostWrite(4'(a), 8'(a + 16));

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] write in IDLE takes effect");
    hostWrite(4'd3, 8'hAA);
    applyStimulus(one_frame);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    cfg_gap = 4'd8; cfg_nframes = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.h_write = 1'b1; bus.h_addr = 4'd5; bus.h_data = 8'h11;
    @(negedge clk);
    bus.h_write = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && seen < 3; k++) begin
      @(negedge clk);
      if (bus.o_strb) seen++;
    end
    checkOutput("mid_frame_strobes", seen, 3);
    checkOutput("pre_reset_wr_err", int'(wr_err), 1);
    n_reset = 1'b0;
    #1;
    checkOutput("midrst_o_strb", int'(bus.o_strb), 0);
    checkOutput("midrst_o_data", int'(bus.o_data), 0);
    checkOutput("midrst_o_sof", int'(bus.o_sof), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_wr_err", int'(wr_err), 0);
    @(negedge clk);
    n_reset = 1'b1;
    applyStimulus(one_frame);

    $display("[TB] start and stop together");
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    busy_seen = 0; strb_seen = 0;
    for (int k = 0; k < 12; k++) begin
      busy_seen += int'(busy);
      strb_seen += int'(bus.o_strb);
      @(negedge clk);
    end
    checkOutput("start_stop_busy", busy_seen, 0);
    checkOutput("start_stop_strb", strb_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Pixel source that drives the 2D filter's strobed input interface: `o_strb` / `o_data` connect to the filter's `i_strb` / `i_data`.
- A host preloads a WIDTH×HEIGHT 8-bit frame into an internal single-port frame memory.
- On `start`, the block replays that frame raster-order, one pixel per fixed period, for N frames back-to-back. This matches the filter's first-frame-discard behaviour.

Parameters:
- WIDTH, 256, pixels per line
- HEIGHT, 256, lines per frame
- MIN_GAP, 8, minimum cycles between strobes (filter pipeline needs ≥7 idle cycles)
- AW, 16, frame memory address width, log2(WIDTH*HEIGHT)

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin streaming (IDLE only)
- stop  in  1  single-cycle pulse; abort at next pixel boundary
- cfg_gap  in  4  strobe period in cycles; clamped to ≥MIN_GAP
- cfg_nframes  in  8  frames to send; 0 = continuous until stop
- h_write  in  1  host frame-memory write strobe
- h_addr  in  AW  host write address
- h_data  in  8  host write data
- o_strb  out  1  pixel strobe, one cycle per pixel
- o_data  out  8  pixel value, valid when o_strb=1
- o_sof  out  1  high with o_strb on pixel (0,0) of every frame
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse on normal completion
- wr_err  out  1  sticky; host write dropped while busy; cleared by accepted start

Behaviour:
- Reset:
  - o_strb=0, o_data=0, o_sof=0, busy=0, done=0, wr_err=0.
  - State IDLE; pixel address, frame count and gap counter = 0.
  - Frame memory is not reset.
- States: IDLE, READ, EMIT, WAIT.
- IDLE:
  - Host writes are accepted: cs=we=1, addr=h_addr.
  - On start (stop=0), latch:
    - gap_r = max(cfg_gap, MIN_GAP)
    - nfr_r = cfg_nframes
  - Also clear pix_addr, frame_cnt and wr_err; set busy; go to READ.
  - start with stop in the same cycle: stay IDLE. start while busy: ignored.
- READ (1 cycle): cs=1, we=0, addr=pix_addr (mem_single read latency is 1). Next state: EMIT.
- EMIT (1 cycle):
  - o_strb<=1, o_data<=dout, o_sof<=(pix_addr==0).
  - Advance pix_addr; wrap WIDTH*HEIGHT-1 → 0 and increment frame_cnt (8-bit) on wrap.
  - Next state: WAIT.
- WAIT: counts gap_r-2 cycles, then:
  - if stop_pend → IDLE, busy=0, done stays 0;
  - else if last pixel of last frame was emitted (nfr_r≠0 and frame_cnt==nfr_r) → IDLE, busy=0, done=1 for one cycle;
  - else → READ.
- o_strb / o_sof are single-cycle pulses; o_data holds its last value between strobes.
- Timing:
  - First o_strb is registered 2 cycles after the edge that samples start.
  - Consecutive strobes are exactly gap_r cycles apart, including across line and frame wraps. No bubbles allowed, because the filter's coordinate tracking depends on this.
- stop:
  - Sets stop_pend in any busy state.
  - A pixel already in READ/EMIT is still emitted in full; no new read is issued.
  - stop in IDLE: no effect.
- Host writes while busy: dropped (streamer owns the memory port); wr_err<=1.
- Continuous mode (nfr_r=0): frame_cnt wraps freely; only stop ends the run.
- Reset mid-stream: all registers return to reset values immediately; no partial strobe.

Decomposition:
- Package frame_streamer_pkg:
  - WIDTH/HEIGHT/MIN_GAP defaults
  - pixel_t (8-bit)
  - state enum {IDLE, READ, EMIT, WAIT}
  - function clamp_gap
- Sub-module: existing mem_single (WD=8, DEPTH=WIDTH*HEIGHT); address/cs/we muxed between host and streamer.
- Everything else is one module.

Test Plan (bench uses WIDTH=4, HEIGHT=4 for speed unless noted):
- Load mem[a]=a+16 for a=0..15; start, cfg_gap=8, cfg_nframes=1 → 16 strobes 8 cycles apart, o_data 16..31, o_sof only with first, done pulses once 8 cycles after last strobe's period start, busy low after.
- cfg_gap=3 → period clamped to 8; cfg_gap=12 → period exactly 12.
- cfg_nframes=2 → 32 strobes, uniform period across the frame wrap, o_sof on strobes 1 and 17, one done.
- cfg_nframes=0, stop pulsed 2 cycles after strobe 5 → exactly 5 strobes, busy falls within that period, done=0.
- h_write addr 3 data 0xAA while busy → wr_err=1, streamed pixel 3 of the next frame unchanged. Next start clears wr_err; write in IDLE takes effect.
- n_reset asserted mid-frame → all outputs 0 that cycle. Restart after reset streams from pixel 0 with memory contents intact.
